// File: rtl/fetch_packet_unpacker.sv
// Fetch-packet unpacker: pops one wide packet from the fetch FIFO and hands its
// valid slots to decode one per cycle, lowest slot first.
module fetch_packet_unpacker #(
    parameter int SLOT_NUM   = 4,
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int PKT_WIDTH  = ADDR_WIDTH + SLOT_NUM + SLOT_NUM * INST_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [PKT_WIDTH-1:0]        fifo_data,
    input  logic                        fifo_data_valid,
    output logic                        fifo_pop,
    output logic [INST_WIDTH-1:0]       inst_out,
    output logic [ADDR_WIDTH-1:0]       inst_pc,
    output logic [$clog2(SLOT_NUM)-1:0] inst_slot,
    output logic                        inst_last,
    output logic                        inst_valid,
    input  logic                        inst_ready
);
    localparam int SLOT_W = $clog2(SLOT_NUM);

    logic [ADDR_WIDTH-1:0]                pkt_pc;
    logic [SLOT_NUM-1:0][INST_WIDTH-1:0]  pkt_inst;
    logic [SLOT_NUM-1:0]                  pending;
    logic [SLOT_W-1:0]                    cur;
    logic                                 busy;
    logic                                 fire;
    logic                                 load;

    logic [ADDR_WIDTH-1:0]                in_pc;
    logic [SLOT_NUM-1:0]                  in_mask;
    logic [SLOT_NUM-1:0][INST_WIDTH-1:0]  in_inst;

    assign in_pc   = fifo_data[PKT_WIDTH-1 -: ADDR_WIDTH];
    assign in_mask = fifo_data[SLOT_NUM*INST_WIDTH +: SLOT_NUM];
    assign in_inst = fifo_data[SLOT_NUM*INST_WIDTH-1:0];

    // Lowest pending slot wins; scan high-to-low so the last hit is the lowest.
    always_comb begin
        cur = '0;
        for (int i = SLOT_NUM - 1; i >= 0; i--) begin
            if (pending[i]) cur = SLOT_W'(i);
        end
    end

    assign busy       = |pending;
    assign inst_valid = busy;
    assign inst_slot  = cur;
    assign inst_out   = pkt_inst[cur];
    assign inst_pc    = pkt_pc + ADDR_WIDTH'({cur, 2'b00});
    assign inst_last  = busy && ((pending & (pending - 1'b1)) == '0);

    assign fire     = busy && inst_ready;
    // Refill when empty, or in the same cycle the final slot leaves, so there is no bubble.
    assign load     = !rst && !flush && fifo_data_valid && (!busy || (fire && inst_last));
    assign fifo_pop = load;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pending <= '0;
        end else if (load) begin
            pending  <= in_mask;
            pkt_pc   <= in_pc;
            pkt_inst <= in_inst;
        end else if (fire) begin
            pending[cur] <= 1'b0;
        end
    end
endmodule
